// File: rtl/dsd128_tap_rom.sv
// dsd128_tap_rom
// Coefficient ROM and sign-select stage for the 2-channel DSD128 -> 176.4 kHz
// decimate-by-32 FIR (320 taps, 10 taps per bck over 32 slots).
// For slot addr, lane k reads c[ADDER_COUNT*addr + k]. Each channel then emits
// +c or -c, chosen by its DSD bit (1 -> +c, 0 -> -c).
//
// Ports
//   bck                 bit clock; only used when REGISTERED=1
//   reset_n             async active-low clear of the output registers
//   addr[4:0]           slot index 0..31
//   x0..x9 / y0..y9     left / right DSD bits for taps k=0..9
//   tap_left0..9        signed 32-bit left terms
//   tap_right0..9       signed 32-bit right terms
//
// Coefficient sets (COEF_SET)
//   0: lowpass kernel = three cascaded boxcars whose lengths sum to NTAP+2,
//      scaled by 1024. The kernel is symmetric, every entry is non-zero, and
//      sum |c| = 1266167808 (< 2^31-1). No entry can reach -2^31.
//   1: ramp table c[n] = n+1, used for bring-up and address checks.
// The table is folded into per-lane constant LUTs at elaboration, so no
// entry can ever be uninitialised.
module dsd128_tap_rom #(
  parameter int NTAP        = 320,
  parameter int ADDER_COUNT = 10,
  parameter int DEC_FACTOR  = 32,
  parameter int COEF_SET    = 0,
  parameter bit REGISTERED  = 1'b0
) (
  input  logic               bck,
  input  logic               reset_n,
  input  logic [4:0]         addr,
  input  logic               x0, x1, x2, x3, x4, x5, x6, x7, x8, x9,
  input  logic               y0, y1, y2, y3, y4, y5, y6, y7, y8, y9,
  output logic signed [31:0] tap_left0, tap_left1, tap_left2, tap_left3, tap_left4,
  output logic signed [31:0] tap_left5, tap_left6, tap_left7, tap_left8, tap_left9,
  output logic signed [31:0] tap_right0, tap_right1, tap_right2, tap_right3, tap_right4,
  output logic signed [31:0] tap_right5, tap_right6, tap_right7, tap_right8, tap_right9
);

  localparam int COEF_SCALE = 1024;

  // c[n] for the boxcar cascade. This is the number of ways to write n as
  // a+b+d with a<l1, b<l2, d<l3. The count over b is done in closed form,
  // so only the loop over a remains.
  function automatic logic [31:0] coef_of(input int n);
    int l1, l2, l3, lo, hi, cnt;
    l1  = (NTAP + 2) / 3;
    l2  = l1;
    l3  = NTAP + 2 - l1 - l2;
    cnt = 0;
    for (int a = 0; a < l1; a++) begin
      lo = n - a - (l3 - 1);
      if (lo < 0) lo = 0;
      hi = n - a;
      if (hi > l2 - 1) hi = l2 - 1;
      if (hi >= lo) cnt += hi - lo + 1;
    end
    if (COEF_SET == 1) return 32'(n + 1);
    return 32'(cnt * COEF_SCALE);
  endfunction

  logic [ADDER_COUNT-1:0]       w_x, w_y;
  logic [ADDER_COUNT-1:0][31:0] w_l, w_r, r_l, r_r, w_outl, w_outr;

  assign w_x = {x9, x8, x7, x6, x5, x4, x3, x2, x1, x0};
  assign w_y = {y9, y8, y7, y6, y5, y4, y3, y2, y1, y0};

  // One lane per tap k. Each lane has a 32-entry constant LUT indexed by addr.
  // Both channels share the coefficient and differ only in the sign select.
  for (genvar k = 0; k < ADDER_COUNT; k++) begin : g_lane
    logic [DEC_FACTOR-1:0][31:0] w_rom;
    logic [31:0]                 w_coef;
    for (genvar s = 0; s < DEC_FACTOR; s++) begin : g_slot
      localparam logic [31:0] C = coef_of(s * ADDER_COUNT + k);
      assign w_rom[s] = C;
    end
    assign w_coef = w_rom[addr];
    assign w_l[k] = w_x[k] ? w_coef : (~w_coef + 32'd1);
    assign w_r[k] = w_y[k] ? w_coef : (~w_coef + 32'd1);
  end

  // Output stage. In the registered variant, reset clears any term in flight.
  always_ff @(posedge bck or negedge reset_n) begin
    if (!reset_n) begin
      r_l <= '0;
      r_r <= '0;
    end else begin
      r_l <= w_l;
      r_r <= w_r;
    end
  end

  assign w_outl = REGISTERED ? r_l : w_l;
  assign w_outr = REGISTERED ? r_r : w_r;

  assign tap_left0  = w_outl[0];
  assign tap_left1  = w_outl[1];
  assign tap_left2  = w_outl[2];
  assign tap_left3  = w_outl[3];
  assign tap_left4  = w_outl[4];
  assign tap_left5  = w_outl[5];
  assign tap_left6  = w_outl[6];
  assign tap_left7  = w_outl[7];
  assign tap_left8  = w_outl[8];
  assign tap_left9  = w_outl[9];
  assign tap_right0 = w_outr[0];
  assign tap_right1 = w_outr[1];
  assign tap_right2 = w_outr[2];
  assign tap_right3 = w_outr[3];
  assign tap_right4 = w_outr[4];
  assign tap_right5 = w_outr[5];
  assign tap_right6 = w_outr[6];
  assign tap_right7 = w_outr[7];
  assign tap_right8 = w_outr[8];
  assign tap_right9 = w_outr[9];

endmodule

// File: tb/tb_dsd128_tap_rom.sv
// Bench for dsd128_tap_rom.
// Three instances share one set of inputs:
//   u_ramp  ramp table (c[n]=n+1), combinational
//   u_prod  production table, combinational
//   u_reg   production table, registered
// The production table is rebuilt here by convolving three boxcars with arrays.
module tb_dsd128_tap_rom;

  logic       bck = 1'b0;
  logic       reset_n;
  logic [4:0] addr;
  logic [9:0] xv, yv;

  logic [31:0] rl[10], rr[10], pl[10], pr[10], gl[10], gr[10];

  int    prod_c[320];
  int    ncmp = 0;
  int    nerr = 0;
  logic  rv = 1'b0;
  logic [4:0] cap_a;
  logic [9:0] cap_x, cap_y;
  int    dc[320];
  longint dsum, msum;

  always #5 bck = ~bck;

  dsd128_tap_rom #(.COEF_SET(1), .REGISTERED(1'b0)) u_ramp (
    .bck(bck), .reset_n(reset_n), .addr(addr),
    .x0(xv[0]), .x1(xv[1]), .x2(xv[2]), .x3(xv[3]), .x4(xv[4]),
    .x5(xv[5]), .x6(xv[6]), .x7(xv[7]), .x8(xv[8]), .x9(xv[9]),
    .y0(yv[0]), .y1(yv[1]), .y2(yv[2]), .y3(yv[3]), .y4(yv[4]),
    .y5(yv[5]), .y6(yv[6]), .y7(yv[7]), .y8(yv[8]), .y9(yv[9]),
    .tap_left0(rl[0]), .tap_left1(rl[1]), .tap_left2(rl[2]), .tap_left3(rl[3]), .tap_left4(rl[4]),
    .tap_left5(rl[5]), .tap_left6(rl[6]), .tap_left7(rl[7]), .tap_left8(rl[8]), .tap_left9(rl[9]),
    .tap_right0(rr[0]), .tap_right1(rr[1]), .tap_right2(rr[2]), .tap_right3(rr[3]), .tap_right4(rr[4]),
    .tap_right5(rr[5]), .tap_right6(rr[6]), .tap_right7(rr[7]), .tap_right8(rr[8]), .tap_right9(rr[9])
  );

  dsd128_tap_rom #(.COEF_SET(0), .REGISTERED(1'b0)) u_prod (
    .bck(bck), .reset_n(reset_n), .addr(addr),
    .x0(xv[0]), .x1(xv[1]), .x2(xv[2]), .x3(xv[3]), .x4(xv[4]),
    .x5(xv[5]), .x6(xv[6]), .x7(xv[7]), .x8(xv[8]), .x9(xv[9]),
    .y0(yv[0]), .y1(yv[1]), .y2(yv[2]), .y3(yv[3]), .y4(yv[4]),
    .y5(yv[5]), .y6(yv[6]), .y7(yv[7]), .y8(yv[8]), .y9(yv[9]),
    .tap_left0(pl[0]), .tap_left1(pl[1]), .tap_left2(pl[2]), .tap_left3(pl[3]), .tap_left4(pl[4]),
    .tap_left5(pl[5]), .tap_left6(pl[6]), .tap_left7(pl[7]), .tap_left8(pl[8]), .tap_left9(pl[9]),
    .tap_right0(pr[0]), .tap_right1(pr[1]), .tap_right2(pr[2]), .tap_right3(pr[3]), .tap_right4(pr[4]),
    .tap_right5(pr[5]), .tap_right6(pr[6]), .tap_right7(pr[7]), .tap_right8(pr[8]), .tap_right9(pr[9])
  );

  dsd128_tap_rom #(.COEF_SET(0), .REGISTERED(1'b1)) u_reg (
    .bck(bck), .reset_n(reset_n), .addr(addr),
    .x0(xv[0]), .x1(xv[1]), .x2(xv[2]), .x3(xv[3]), .x4(xv[4]),
    .x5(xv[5]), .x6(xv[6]), .x7(xv[7]), .x8(xv[8]), .x9(xv[9]),
    .y0(yv[0]), .y1(yv[1]), .y2(yv[2]), .y3(yv[3]), .y4(yv[4]),
    .y5(yv[5]), .y6(yv[6]), .y7(yv[7]), .y8(yv[8]), .y9(yv[9]),
    .tap_left0(gl[0]), .tap_left1(gl[1]), .tap_left2(gl[2]), .tap_left3(gl[3]), .tap_left4(gl[4]),
    .tap_left5(gl[5]), .tap_left6(gl[6]), .tap_left7(gl[7]), .tap_left8(gl[8]), .tap_left9(gl[9]),
    .tap_right0(gr[0]), .tap_right1(gr[1]), .tap_right2(gr[2]), .tap_right3(gr[3]), .tap_right4(gr[4]),
    .tap_right5(gr[5]), .tap_right6(gr[6]), .tap_right7(gr[7]), .tap_right8(gr[8]), .tap_right9(gr[9])
  );

  // Production kernel: box(107) * box(107) * box(108), scaled by 1024.
  initial begin
    int b2[213];
    for (int i = 0; i < 213; i++) b2[i] = 0;
    for (int i = 0; i < 320; i++) prod_c[i] = 0;
    for (int i = 0; i < 107; i++)
      for (int j = 0; j < 107; j++) b2[i+j] += 1;
    for (int i = 0; i < 213; i++)
      for (int j = 0; j < 108; j++) prod_c[i+j] += b2[i] * 1024;
  end

  // Term k at slot a: the ramp table uses c[n]=n+1; bit 1 selects +c, bit 0 selects -c.
  function automatic logic [31:0] term(input bit ramp, input int a, input int k, input bit b);
    int c;
    c = ramp ? (a * 10 + k + 1) : prod_c[a * 10 + k];
    return b ? 32'(c) : 32'(-c);
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] got, input logic [31:0] exp);
    ncmp++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s[%0d] got %0d (0x%08h) expected %0d (0x%08h) t=%0t",
               name, idx, $signed(got), got, $signed(exp), exp, $time);
    end
  endtask

  // Registered-path model: the inputs seen at the last bck edge, valid only
  // after an edge taken while out of reset.
  always @(posedge bck or negedge reset_n) rv <= reset_n;
  always @(posedge bck) begin
    cap_a <= addr;
    cap_x <= xv;
    cap_y <= yv;
  end

  // Every-cycle compare of all three instances.
  always @(negedge bck) begin
    for (int k = 0; k < 10; k++) begin
      chk("ramp_l", k, rl[k], term(1'b1, int'(addr), k, xv[k]));
      chk("ramp_r", k, rr[k], term(1'b1, int'(addr), k, yv[k]));
      chk("prod_l", k, pl[k], term(1'b0, int'(addr), k, xv[k]));
      chk("prod_r", k, pr[k], term(1'b0, int'(addr), k, yv[k]));
      chk("reg_l", k, gl[k], (reset_n && rv) ? term(1'b0, int'(cap_a), k, cap_x[k]) : 32'd0);
      chk("reg_r", k, gr[k], (reset_n && rv) ? term(1'b0, int'(cap_a), k, cap_y[k]) : 32'd0);
    end
  end

  task automatic drive_rand();
    @(posedge bck); #1;
    addr = 5'($urandom_range(0, 31));
    xv   = 10'($urandom);
    yv   = 10'($urandom);
  endtask

  initial begin
    reset_n = 1'b0;
    addr    = '0;
    xv      = '0;
    yv      = '0;
    repeat (3) @(posedge bck);
    #1;
    for (int k = 0; k < 10; k++) begin
      chk("rst_l", k, gl[k], 32'd0);
      chk("rst_r", k, gr[k], 32'd0);
    end
    reset_n = 1'b1;

    // Ramp: addr 0, all bits 1 -> k+1
    @(posedge bck); #1;
    addr = 5'd0; xv = '1; yv = '1;
    #1;
    for (int k = 0; k < 10; k++) begin
      chk("a0_l", k, rl[k], 32'(k + 1));
      chk("a0_r", k, rr[k], 32'(k + 1));
    end

    // Ramp: addr 31, x all 0, y all 1
    @(posedge bck); #1;
    addr = 5'd31; xv = '0; yv = '1;
    #1;
    for (int k = 0; k < 10; k++) begin
      chk("a31_l", k, rl[k], 32'(-(311 + k)));
      chk("a31_r", k, rr[k], 32'(311 + k));
    end

    // Ramp: addr 5, alternating bits, y = ~x
    @(posedge bck); #1;
    addr = 5'd5; xv = 10'b1010101010; yv = ~10'b1010101010;
    #1;
    chk("a5_l", 0, rl[0], 32'(-51));
    chk("a5_l", 1, rl[1], 32'd52);
    chk("a5_r", 0, rr[0], 32'd51);
    chk("a5_r", 1, rr[1], 32'(-52));

    // Production: sweep all slots with all bits 1
    dsum = 0;
    msum = 0;
    for (int a = 0; a < 32; a++) begin
      @(posedge bck); #1;
      addr = 5'(a); xv = '1; yv = '1;
      #1;
      for (int k = 0; k < 10; k++) begin
        dc[a*10+k] = int'(pl[k]);
        dsum += longint'($signed(pl[k])) + longint'($signed(pr[k]));
        msum += 2 * longint'(prod_c[a*10+k]);
      end
    end
    ncmp++;
    if (dsum != msum) begin
      nerr++;
      $display("FAIL dc_sum got %0d expected %0d", dsum, msum);
    end
    ncmp++;
    if (dsum != 64'd2532335616) begin
      nerr++;
      $display("FAIL dc_sum_lit got %0d expected 2532335616", dsum);
    end
    chk("c_lit", 0, 32'(dc[0]), 32'd1024);
    chk("c_lit", 1, 32'(dc[1]), 32'd3072);
    chk("c_lit", 2, 32'(dc[2]), 32'd6144);
    for (int n = 0; n < 160; n++) chk("sym", n, 32'(dc[n]), 32'(dc[319-n]));

    repeat (5000) drive_rand();

    // Registered path: asynchronous reset in mid-stream, then the first valid term
    drive_rand();
    @(posedge bck); #3;
    reset_n = 1'b0;
    #1;
    for (int k = 0; k < 10; k++) begin
      chk("arst_l", k, gl[k], 32'd0);
      chk("arst_r", k, gr[k], 32'd0);
    end
    @(posedge bck); #1;
    reset_n = 1'b1;
    addr = 5'd0; xv = '1; yv = '1;
    @(posedge bck); #1;
    for (int k = 0; k < 10; k++) begin
      chk("rel_l", k, gl[k], 32'(prod_c[k]));
      chk("rel_r", k, gr[k], 32'(prod_c[k]));
    end
    chk("rel_lit", 0, gl[0], 32'd1024);
    chk("rel_lit", 1, gl[1], 32'd3072);
    chk("rel_lit", 2, gl[2], 32'd6144);

    repeat (5000) drive_rand();
    @(posedge bck); #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule

// File: doc/dsd128_tap_rom.md
Name: dsd128_tap_rom

Overview:
- Coefficient ROM and sign-select stage for the 2-channel DSD128 to 176.4 kHz decimation-by-32 FIR.
- The filter has 320 taps, evaluated 10 taps per bit-clock over 32 slots.
- For each slot address the block returns ten signed coefficient terms per channel. Each term is +c or -c, selected by the corresponding DSD bit.
- The parent filter sums the ten terms per channel into its accumulator every bck cycle.

Parameters:
- NTAP, 320, total FIR taps (= DEC_FACTOR x ADDER_COUNT).
- ADDER_COUNT, 10, taps produced per slot per channel.
- DEC_FACTOR, 32, slots per output sample; addr range is 0..DEC_FACTOR-1.
- COEF_FILE, "dsd128_coef.hex", 320 lines of 32-bit two's-complement hex, loaded at elaboration as c[0..319].
- REGISTERED, 0, 0 = combinational outputs; 1 = outputs registered on bck.

Ports:
- bck  input  1  bit clock (DSD128, 5.6448 MHz); used only when REGISTERED=1.
- reset_n  input  1  asynchronous active-low reset; one clock domain (bck).
- addr  input  5  slot index i, 0..31.
- x0..x9  input  1 each  left-channel DSD bits for taps k=0..9 of the current slot.
- y0..y9  input  1 each  right-channel DSD bits for taps k=0..9.
- tap_left0..tap_left9  output  32 each, signed  left terms.
- tap_right0..tap_right9  output  32 each, signed  right terms.

Behaviour:
- Coefficient index: n = ADDER_COUNT*addr + k, for k = 0..9. addr 31 maps to n = 310..319. Every 5-bit addr value is valid; there is no out-of-range case.
- Sign rule: DSD bit 1 means +1 and bit 0 means -1.
  - tap_leftk = xk ? c[n] : -c[n]
  - tap_rightk = yk ? c[n] : -c[n]
- Both channels share one coefficient set. Left and right terms for the same k differ only in sign.
- Negation is exact 32-bit two's complement. The table must not contain -2^31; tools or a lint check reject it.
- Coefficient table requirements:
  - Linear-phase lowpass, symmetric: c[n] = c[319-n].
  - Scaled so that sum of |c[n]| <= 2^31-1, so a full 320-term accumulation in the parent cannot overflow.
  - Design target: passband ripple <= 0.01 dB to 20 kHz; stopband >= 110 dB from 88.2 kHz.
- The table is a read-only constant. There is no write path; implement it as ROM or LUT/LSRAM initialized content.
- REGISTERED=0:
  - Outputs are purely combinational from addr, x*, y*; latency 0.
  - bck and reset_n have no effect.
  - Outputs are stable within one bck period.
- REGISTERED=1:
  - Outputs update on posedge bck, so latency is 1 cycle; the parent must compensate.
  - reset_n low asynchronously clears all 20 outputs to 0 and holds them while low.
  - The first valid outputs appear on the first posedge after deassertion.
  - Reset mid-operation discards the in-flight term.
- Inputs changing simultaneously (addr and bits) take effect together; there is no ordering dependency.
- No X propagation: all 320 entries must be initialized. A missing entry in COEF_FILE is an elaboration error.

Test Plan:
- Load a test table with c[n] = n+1. Drive addr=0 and all x/y=1 → tap_leftk = tap_rightk = k+1 (1..10).
- Test table, addr=31, x=all 0, y=all 1 → tap_left0 = -311 … tap_left9 = -320; tap_right0 = 311 … tap_right9 = 320.
- Test table, addr=5, x = 10'b1010101010 (x0=0, x1=1, ...), y = ~x:
  - tap_left0 = -51, tap_left1 = +52.
  - tap_right0 = +51, tap_right1 = -52.
- Production table, sweep addr 0..31 with all bits 1:
  - Sum of all terms equals the sum of c[n] (DC gain); the check is exact.
  - c[n] == c[319-n] for every n.
- REGISTERED=1:
  - Assert reset_n=0 mid-stream → all outputs 0 immediately, without waiting for a clock edge.
  - Release, then apply addr=0 with all bits 1 → outputs = c[0..9] one bck after the input is applied.
- Random stimulus, 10k cycles, REGISTERED=0 → every output matches the reference model ±c[10*addr+k] bit-exactly.
